// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, iteration count.
package mdu_pkg;
  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Two's-complement negate: keep bits up to the lowest set bit, flip the ones above it.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    logic [31:0] r;
    logic        seen;
    seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[i] ^ seen;
      seen = seen | x[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/cla32.sv
// 32-bit adder: 4-bit carry-lookahead groups chained group to group.
module cla32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] s_o,
  output logic        c_o
);
  logic [31:0] g, p;
  logic [32:0] c;

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c[0] = c_i;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]) | (&p[B+3:B] & c[B]);
  end

  assign s_o = p ^ c[31:0];
  assign c_o = c[32];
endmodule

// File: rtl/mdu_addsub.sv
// 33-bit add/subtract (x + y or x - y) around the cla32 adder; bit 32 is a plain full-adder slice.
module mdu_addsub (
  input  logic [32:0] x_i,
  input  logic [32:0] y_i,
  input  logic        sub_i,
  output logic [32:0] s_o
);
  logic [31:0] y_eff;
  logic        c31;

  assign y_eff = sub_i ? ~y_i[31:0] : y_i[31:0];

  cla32 u_cla (
    .a_i (x_i[31:0]),
    .b_i (y_eff),
    .c_i (sub_i),
    .s_o (s_o[31:0]),
    .c_o (c31)
  );

  assign s_o[32] = x_i[32] ^ y_i[32] ^ sub_i ^ c31;
endmodule

// File: rtl/mdu32.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers; one shared 33-bit adder.
// state | meaning: IDLE wait for start / accept MTHI,MTLO; RUN 32 shift-add or restoring steps; FIX sign correction, write hi/lo; DONE result pulse
module mdu32
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        mul_q, mul_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;

  logic [32:0] as_x, as_y, as_s;
  logic        as_sub;
  logic        signed_op, neg_res;

  assign signed_op = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
  assign neg_res   = sa_q ^ sb_q;

  mdu_addsub u_addsub (
    .x_i   (as_x),
    .y_i   (as_y),
    .sub_i (as_sub),
    .s_o   (as_s)
  );

  // b stays raw; a negative divisor/multiplicand is handled by flipping add and subtract.
  always_comb begin
    as_x   = '0;
    as_y   = {1'b0, a};
    as_sub = 1'b1;
    case (state_q)
      S_RUN: begin
        as_x   = mul_q ? {1'b0, acc_q[63:32]} : acc_q[63:31];
        as_y   = {sb_q, b_q};
        as_sub = mul_q ? sb_q : ~sb_q;
      end
      S_FIX: as_y = {1'b0, (mul_q && acc_q[31:0] == 32'd0) ? acc_q[63:32] : acc_q[31:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wdata;
        if (wr_lo) lo_d = wdata;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          mul_d   = ~op[1];
          sa_d    = signed_op & a[31];
          sb_d    = signed_op & b[31];
          b_d     = b;
          acc_d   = {32'd0, (signed_op & a[31]) ? as_s[31:0] : a};
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = S_FIX;
        if (mul_q) acc_d = acc_q[0] ? {as_s, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        else       acc_d = as_s[32] ? {acc_q[62:0], 1'b0} : {as_s[31:0], acc_q[30:0], 1'b1};
      end
      S_FIX: begin
        state_d = S_DONE;
        if (mul_q) begin
          hi_d = acc_q[63:32];
          lo_d = acc_q[31:0];
          // A zero low word is the only case where the negation carry reaches the high word.
          if (neg_res) begin
            if (acc_q[31:0] == 32'd0) hi_d = as_s[31:0];
            else begin
              hi_d = ~acc_q[63:32];
              lo_d = as_s[31:0];
            end
          end
        end else begin
          lo_d = (neg_res && b_q != 32'd0) ? as_s[31:0] : acc_q[31:0];
          hi_d = sa_q ? neg32(acc_q[63:32]) : acc_q[63:32];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu32.sv
// Bench for mdu32: scenario tasks drive ops, a done-monitor pops the expected-result queue.
module tb_mdu32;
  logic        clk = 1'b0;
  logic        rst, start, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          k;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  mdu32 dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] ex, ey, sp;
    logic signed [31:0] sx, sy, q, r;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        ex = $signed({{32{x[31]}}, x});
        ey = $signed({{32{y[31]}}, y});
        sp = ex * ey;
        return sp;
      end
      2'b01: return {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (done_prev) begin
        errors++;
        $display("FAIL done_width: done high on consecutive cycles at cycle %0d, required one-cycle pulse", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending operation", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (hi !== mon_e.hi) begin
          errors++;
          $display("FAIL result_hi: got %08h expected %08h", hi, mon_e.hi);
        end
        checks++;
        if (lo !== mon_e.lo) begin
          errors++;
          $display("FAIL result_lo: got %08h expected %08h", lo, mon_e.lo);
        end
        checks++;
        if (cyc - mon_e.k != 34) begin
          errors++;
          $display("FAIL latency: got %0d expected 34", cyc - mon_e.k);
        end
      end
    end
    done_prev <= done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] m;
    m    = model(o, x, y);
    e.hi = m[63:32];
    e.lo = m[31:0];
    e.k  = cyc;
    exp_q.push_back(e);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_complete: busy=%0b pending=%0d, required busy=0 pending=0", name, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %08h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %08h expected 0", lo); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mthi_mtlo();
    wr_hi = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    wr_hi = 1'b0;
    checks++; if (hi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mthi: got %08h expected deadbeef", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL mthi_lo_untouched: got %08h expected 0", lo); end
    wr_lo = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    wr_lo = 1'b0;
    checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo: got %08h expected cafef00d", lo); end
    rst = 1'b1; wr_hi = 1'b1; wdata = 32'h1111_1111;
    tick();
    rst = 1'b0; wr_hi = 1'b0;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_over_mthi: got %08h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_clears_lo: got %08h expected 0", lo); end
  endtask

  task automatic test_mult();
    int k, n;
    k = cyc;
    drive_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %0b expected 1", busy); end
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    checks++; if (cyc - k != 35) begin errors++; $display("FAIL busy_span: busy fell at edge k+%0d expected k+35", cyc - k); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_max_hi: got %08h expected fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_max_lo: got %08h expected 00000001", lo); end
    drive_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_idle("mult_neg3x7");
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi: got %08h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg_lo: got %08h expected ffffffeb", lo); end
    drive_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_idle("mult_minmin");
    drive_op(2'b00, 32'd0, 32'hFFFF_FFFF);
    wait_idle("mult_zero");
  endtask

  task automatic test_div();
    drive_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg7by2");
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %08h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %08h expected ffffffff", hi); end
    drive_op(2'b11, 32'd100, 32'd0);
    wait_idle("divu_by0");
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %08h expected ffffffff", lo); end
    checks++; if (hi !== 32'h0000_0064) begin errors++; $display("FAIL divu0_hi: got %08h expected 00000064", hi); end
    drive_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_overflow");
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %08h expected 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %08h expected 0", hi); end
    drive_op(2'b10, 32'hFFFF_FFFB, 32'd0);
    wait_idle("div_neg_by0");
    drive_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_idle("div_7byneg2");
  endtask

  task automatic test_busy_ignore();
    int k;
    logic seen;
    k = cyc;
    drive_op(2'b11, 32'd10, 32'd3);
    while (cyc < k + 5) tick();
    start = 1'b1; op = 2'b01; a = 32'h0000_0077; b = 32'h0000_0099;
    tick();
    start = 1'b0; wr_hi = 1'b1; wdata = 32'hBAD0_BAD0;
    tick();
    wr_hi = 1'b0;
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL mthi_while_busy: got %08h expected 00000001", hi); end
    wait_idle("divu_10by3");
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %08h expected 3", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %08h expected 1", hi); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy || done) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL start_not_queued: activity=%0b expected 0", seen); end
  endtask

  task automatic test_start_with_write();
    wr_lo = 1'b1; wdata = 32'h0000_5555;
    drive_op(2'b01, 32'd3, 32'd4);
    wr_lo = 1'b0;
    checks++; if (lo !== 32'h0000_5555) begin errors++; $display("FAIL write_with_start: got %08h expected 00005555", lo); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_with_write_busy: got %0b expected 1", busy); end
    wait_idle("multu_3x4");
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL fix_overwrites_lo: got %08h expected 0000000c", lo); end
  endtask

  task automatic test_reset_abort();
    int k;
    logic seen;
    k = cyc;
    drive_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    while (cyc < k + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %08h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL abort_lo: got %08h expected 0", lo); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: done seen=%0b expected 0", seen); end
    wr_lo = 1'b1; wdata = 32'h0000_1234;
    tick();
    wr_lo = 1'b0;
    checks++; if (lo !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_after_abort: got %08h expected 00001234", lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] edge_v[6];
    logic [31:0] x, y;
    logic [1:0]  o;
    logic [63:0] last;
    edge_v[0] = 32'h0000_0000; edge_v[1] = 32'h0000_0001; edge_v[2] = 32'h7FFF_FFFF;
    edge_v[3] = 32'h8000_0000; edge_v[4] = 32'hFFFF_FFFF; edge_v[5] = 32'h0001_0000;
    last = '0;
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      last = model(o, x, y);
      drive_op(o, x, y);
      wait_idle("back_to_back");
    end
    tick(); tick(); tick();
    checks++; if (hi !== last[63:32]) begin errors++; $display("FAIL hold_hi: got %08h expected %08h", hi, last[63:32]); end
    checks++; if (lo !== last[31:0]) begin errors++; $display("FAIL hold_lo: got %08h expected %08h", lo, last[31:0]); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_busy_ignore();
    test_start_with_write();
    test_reset_abort();
    test_back_to_back();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu32.md
MDU32 -- requirements
Module: mdu32

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 Port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 Port a, input, 32 bits: multiplicand or dividend; sampled with start.
REQ-007 Port b, input, 32 bits: multiplier or divisor; sampled with start.
REQ-008 Port wr_hi, input, 1 bit: MTHI strobe.
REQ-009 Port wr_lo, input, 1 bit: MTLO strobe.
REQ-010 Port wdata, input, 32 bits: data for MTHI/MTLO.
REQ-011 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse; hi/lo are final while it is high.
REQ-013 Port hi, output, 32 bits: HI register (product high word or remainder).
REQ-014 Port lo, output, 32 bits: LO register (product low word or quotient).

Function
REQ-015 The FSM SHALL have four states, IDLE, RUN, FIX and DONE, with transitions: IDLE->RUN on start; RUN->FIX after 32 RUN cycles (5-bit counter); FIX->DONE; DONE->IDLE.
REQ-016 start SHALL be accepted at edge k; done SHALL be high for exactly the single cycle following edge k+34; busy SHALL be high from edge k+1 up to edge k+35.
REQ-017 At acceptance, the signed ops SHALL latch |a| and |b| plus the sign flags; the unsigned ops SHALL latch the operands unchanged; |0x80000000| SHALL be taken as 0x80000000 unsigned.
REQ-018 Multiply SHALL use radix-2 shift-add: each RUN cycle does one conditional 33-bit add into a 64-bit accumulator, followed by a right shift.
REQ-019 Divide SHALL use restoring division: each RUN cycle shifts the remainder:quotient pair left by 1, trial-subtracts the divisor with a 33-bit add/sub, restores on a negative result, and sets the quotient bit otherwise.
REQ-020 FIX SHALL correct signs and write hi/lo:
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: negate the quotient when the operand signs differ; the remainder takes the dividend's sign.
REQ-021 Arithmetic SHALL wrap modulo 2^32 per word; DIV 0x80000000/0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-022 A divisor of 0 SHALL give lo=0xFFFFFFFF and hi=a (the original, unsigned-view dividend), with the same 34-cycle latency and no error flag.
REQ-023 start asserted while busy SHALL be ignored, with no queuing.
REQ-024 wr_hi/wr_lo SHALL load wdata in IDLE and SHALL be ignored while busy.
REQ-025 If start and wr_hi/wr_lo occur together in IDLE, both SHALL take effect; the write is visible until FIX overwrites it.
REQ-026 hi/lo SHALL hold their values between operations and SHALL change only in FIX, on MTHI/MTLO, or on reset.

Reset
REQ-027 On rst the state SHALL go to IDLE, and busy=0, done=0, hi=0, lo=0, counter=0 in the next cycle.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse; rst SHALL take priority over start and wr_hi/wr_lo in the same cycle.

Structure
REQ-029 Package mdu_pkg SHALL hold the op encodings, the state enum and the constant ITER=32.
REQ-030 A single sub-module, mdu_addsub, SHALL implement the 33-bit add/subtract, built from the team's cla32 adder; it is the only arithmetic instance, shared by multiply, divide and the FIX negation.
REQ-031 The hi/lo registers SHALL live inside mdu32.

Verification
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start edge.
REQ-033 MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-036 Start DIVU 10/3; pulse start with new operands at cycle 5 and wr_hi at cycle 6 -> both ignored; result lo=3, hi=1.
REQ-037 Start MULTU, assert rst at cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse ever; then MTLO 0x1234 in IDLE -> lo=0x1234.
